// File: rtl/nfc_page_buffer.sv
`default_nettype none
// ============================================================================
// Module   : nfc_page_buffer
// Purpose  : Multi-bank page buffer between the host-side and flash-side data
//            paths of a NAND controller. Banks form a circular queue: the
//            producer fills banks in order, and the consumer drains closed
//            banks in the same order without bubbles between banks.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            i_wr_valid/o_wr_ready/i_wr_data/i_wr_last/i_wr_abort
//                               - producer side (fill / close / discard)
//            o_rd_valid/i_rd_ready/o_rd_data/o_rd_last
//                               - consumer side (registered output stage)
//            o_full_banks       - closed, not yet released bank count
//            o_empty            - no closed banks and no word on the output
// Revision : 1.0 - initial release
// ============================================================================
module nfc_page_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2048,
    parameter int NBANK  = 2,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(NBANK + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_last,
    input  logic              i_wr_abort,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_last,
    output logic [CNT_W-1:0]  o_full_banks,
    output logic              o_empty
);

    localparam int                BANK_W      = $clog2(NBANK);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [BANK_W-1:0] c_LAST_BANK = BANK_W'(NBANK - 1);

    logic [DATA_W-1:0] r_mem [NBANK][DEPTH];
    logic [NBANK-1:0]  r_full;
    logic [ADDR_W-1:0] r_len [NBANK];

    logic [BANK_W-1:0] r_wb;
    logic [ADDR_W-1:0] r_wa;
    logic [BANK_W-1:0] r_fb;
    logic [ADDR_W-1:0] r_fa;
    logic [BANK_W-1:0] r_tag;

    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_last;
    logic [CNT_W-1:0]  r_full_banks;

    logic              w_wr_ready;
    logic              w_wr_fire;
    logic              w_close;
    logic              w_fetch;
    logic              w_fetch_last;
    logic              w_release;
    logic [BANK_W-1:0] w_wb_next;
    logic [BANK_W-1:0] w_fb_next;

    // Banks are closed and released in order, so the bank under the write
    // pointer is full only when every bank is full.
    assign w_wr_ready   = !r_full[r_wb] && !rst;
    // Abort wins over a same-cycle handshake: the word is dropped.
    assign w_wr_fire    = i_wr_valid && w_wr_ready && !i_wr_abort;
    assign w_close      = w_wr_fire && (i_wr_last || (r_wa == c_LAST_ADDR));
    // The fetch pointer leaves a bank right after its last word, so a full
    // bank under it always has words left to fetch.
    assign w_fetch      = r_full[r_fb] && (!r_rd_valid || i_rd_ready);
    assign w_fetch_last = (r_fa == r_len[r_fb]);
    assign w_release    = r_rd_valid && i_rd_ready && r_rd_last;
    assign w_wb_next    = (r_wb == c_LAST_BANK) ? '0 : r_wb + BANK_W'(1);
    assign w_fb_next    = (r_fb == c_LAST_BANK) ? '0 : r_fb + BANK_W'(1);

    // Storage has no reset; contents are meaningless until a bank closes.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wb][r_wa] <= i_wr_data;
        end
    end

    // Write pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb <= '0;
            r_wa <= '0;
        end else if (i_wr_abort) begin
            r_wa <= '0;
        end else if (w_wr_fire) begin
            if (w_close) begin
                r_wb <= w_wb_next;
                r_wa <= '0;
            end else begin
                r_wa <= r_wa + ADDR_W'(1);
            end
        end
    end

    // Per-bank state. A close and a release in one cycle never hit the same
    // bank, so the two updates are independent.
    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_full[b] <= 1'b0;
                r_len[b]  <= '0;
            end else begin
                if (w_release && (r_tag == BANK_W'(b))) begin
                    r_full[b] <= 1'b0;
                end
                if (w_close && (r_wb == BANK_W'(b))) begin
                    r_full[b] <= 1'b1;
                    r_len[b]  <= r_wa;
                end
            end
        end
    end

    // Closed-bank counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full_banks <= '0;
        end else if (w_close && !w_release) begin
            r_full_banks <= r_full_banks + CNT_W'(1);
        end else if (w_release && !w_close) begin
            r_full_banks <= r_full_banks - CNT_W'(1);
        end
    end

    // Fetch pointers and registered output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fb       <= '0;
            r_fa       <= '0;
            r_tag      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_last  <= 1'b0;
        end else if (w_fetch) begin
            r_rd_data  <= r_mem[r_fb][r_fa];
            r_rd_last  <= w_fetch_last;
            r_rd_valid <= 1'b1;
            r_tag      <= r_fb;
            if (w_fetch_last) begin
                r_fb <= w_fb_next;
                r_fa <= '0;
            end else begin
                r_fa <= r_fa + ADDR_W'(1);
            end
        end else if (i_rd_ready) begin
            r_rd_valid <= 1'b0;
        end
    end

    assign o_wr_ready   = w_wr_ready;
    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = r_rd_data;
    assign o_rd_last    = r_rd_last;
    assign o_full_banks = r_full_banks;
    assign o_empty      = (r_full_banks == '0) && !r_rd_valid;

endmodule
`default_nettype wire

// File: doc/nfc_page_buffer.md
# nfc_page_buffer

Parametrised multi-bank page buffer between the NAND controller's host-side data path and its flash-side data path. Each bank holds one page, and banks form a circular queue: the producer fills banks in order, and the consumer drains closed banks in the same order. Back-to-back banks stream without bubbles. It generalises the single-page buffer unit with configurable width, page depth and bank count, early page close, and fill abort.

## Interface
Parameters:
- DATA_W, 8, data word width in bits
- DEPTH, 2048, words per bank (one page); must be ≥ 2
- NBANK, 2, number of banks; must be ≥ 2
- ADDR_W, $clog2(DEPTH), derived word-address width
- CNT_W, $clog2(NBANK+1), derived width of the bank count

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_valid  in  1  producer word valid
- wr_ready  out  1  buffer can accept a word; equals !full[wb] && !rst
- wr_data  in  DATA_W  producer word
- wr_last  in  1  closes the current fill bank after this word
- wr_abort  in  1  discards the partially filled bank
- rd_valid  out  1  rd_data holds a valid word (registered)
- rd_ready  in  1  consumer accepts the word
- rd_data  out  DATA_W  consumer word (registered)
- rd_last  out  1  rd_data is the final word of its bank (registered)
- full_banks  out  CNT_W  number of closed, unreleased banks (registered)
- empty  out  1  full_banks==0 and rd_valid==0

## Operation
- Storage: NBANK×DEPTH words. Per-bank state is full[b] and len[b] (last address, ADDR_W bits).
- Write side:
  - Pointers are wb (bank) and wa (address).
  - A write handshake is wr_valid && wr_ready; it writes mem[wb][wa] = wr_data.
  - A bank closes when the handshake carries wr_last, or when wa==DEPTH-1 (auto-close). On close: full[wb]=1, len[wb]=wa, wb = (wb+1) mod NBANK, wa=0.
  - Otherwise each handshake increments wa.
- wr_abort:
  - Sets wa=0 and takes priority over a same-cycle write handshake (the word is dropped).
  - Has no effect on closed banks.
- Read side, fetch pointers fb and fa:
  - A fetch occurs when full[fb] && fa is not yet past len[fb] && (!rd_valid || rd_ready).
  - A fetch loads rd_data=mem[fb][fa], sets rd_last=(fa==len[fb]), sets rd_valid=1, and records tag=fb.
  - Fetching the last word sets fb=(fb+1) mod NBANK and fa=0; otherwise fa increments.
  - If no fetch occurs and rd_ready is high, rd_valid clears.
- Release: a consumer handshake with rd_last clears full[tag]. Only then may the producer reuse that bank.
- full_banks increments on close and decrements on release. A simultaneous close and release leaves it unchanged.
- A close and a release in the same cycle always target different banks, so there is no conflict.
- Reset mid-operation: all buffered data is discarded. Memory contents are don't-care.

## Timing
- Reset values:
  - wb, wa, fb, fa, tag = 0
  - all full[] = 0
  - rd_valid = 0, rd_data = 0, rd_last = 0
  - full_banks = 0, empty = 1
  - wr_ready = 0 while rst is high, 1 on the first cycle after rst falls
- Write throughput is 1 word/clk while wr_ready is high.
- Read latency: after the edge that closes a bank (with the read side idle), rd_valid rises on the next edge (1 clk).
- Read throughput is 1 word/clk under continuous rd_ready, including across bank boundaries.
- rd_data, rd_last and rd_valid hold stable while rd_valid && !rd_ready.
- wr_ready is based on registered full[], so a bank released at edge T accepts writes from cycle T+1.
- With all NBANK banks full, wr_ready=0 and any write is ignored.

## Test plan
- Single page, DATA_W=8, DEPTH=16, NBANK=2: write 0x00..0x0F with auto-close, then read with rd_ready=1 -> 16 words 0x00..0x0F; rd_last only on 0x0F; rd_valid rises 1 clk after the close edge; full_banks 0→1→0.
- Short page: write 5 words with wr_last on the 5th -> exactly 5 words read, rd_last on the 5th, next bank starts at address 0.
- Backpressure and full: fill both banks with rd_ready=0 -> wr_ready=0 and full_banks=2; a 33rd write is ignored. Raise rd_ready -> 32 words in order with no bubble at the bank boundary; wr_ready returns 1 the cycle after the first rd_last handshake.
- Random rd_ready stalls -> rd_data/rd_last held stable during stalls; output sequence identical to a reference queue.
- Abort: write 3 words, pulse wr_abort, write 4 words plus wr_last -> only the 4 later words are read; abort together with a write handshake drops that word.
- Reset mid-read: assert rst while rd_valid=1 and full_banks=2 -> rd_valid=0, full_banks=0, empty=1 immediately (asynchronous); a subsequent fresh page reads correctly.
